// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, FSM states and byte-enable helper for dmem_bytelane
package dmem_pkg;
   localparam logic [1:0] SZ_BYTE  = 2'd0;
   localparam logic [1:0] SZ_HALF  = 2'd1;
   localparam logic [1:0] SZ_WORD  = 2'd2;
   localparam logic [1:0] SZ_DWORD = 2'd3;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] lane);
      return 8'(((9'd1 << (4'd1 << size)) - 9'd1) << lane);
   endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores, extension for loads, alignment check
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int NB = DATA_W / 8,
   localparam int LB = $clog2(NB)
) (
   input  logic [1:0]        size,
   input  logic [LB-1:0]     lane,
   input  logic              uns,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rword,
   output logic [NB-1:0]     be,
   output logic [DATA_W-1:0] wdata_al,
   output logic [DATA_W-1:0] rdata_ext,
   output logic              misalign
);
   logic [2:0]        lane3;
   logic [DATA_W-1:0] sh, keep, msb;

   // keep masks the access width; msb is its top bit, used as the sign source
   always_comb begin
      lane3     = 3'(lane);
      be        = NB'(byte_mask(size, lane3));
      misalign  = |(lane3 & 3'((4'd1 << size) - 4'd1));
      wdata_al  = wdata << {lane, 3'b000};
      sh        = rword >> {lane, 3'b000};
      keep      = (32'(size) >= LB) ? '1 : (DATA_W'(1) << (7'd8 << size)) - DATA_W'(1);
      msb       = keep & ~(keep >> 1);
      rdata_ext = (sh & keep) | ({DATA_W{~uns && |(sh & msb)}} & ~keep);
   end
endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-addressable data memory with init sweep and fixed-latency responses
module dmem_bytelane
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH = 64,
   parameter int RD_LAT = 1,
   parameter logic [DATA_W-1:0] INIT_VAL = '1,
   localparam int NB = DATA_W / 8,
   localparam int LB = $clog2(NB),
   localparam int WI = $clog2(DEPTH),
   localparam int ADDR_W = WI + LB
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);
   localparam int PW = RD_LAT * DATA_W;

   state_t                        state, state_nx;
   logic [WI-1:0]                 cnt;
   logic [DATA_W-1:0]             mem [DEPTH];
   logic [LB-1:0]                 lane;
   logic [WI-1:0]                 widx;
   logic [NB-1:0]                 be;
   logic [DATA_W-1:0]             wal, rext, d0;
   logic                          misalign, err, acc;
   logic [RD_LAT-1:0]             pv, pe;
   logic [RD_LAT-1:0][DATA_W-1:0] pd;

   assign lane = req_addr[LB-1:0];
   assign widx = req_addr[ADDR_W-1:LB];
   assign acc  = req_valid && req_ready;
   assign err  = (32'(req_size) > LB) || misalign;
   assign d0   = (acc && !req_we && !err) ? rext : '0;

   dmem_lane_align #(.DATA_W(DATA_W)) u_align (
      .size     (req_size),
      .lane     (lane),
      .uns      (req_unsigned),
      .wdata    (req_wdata),
      .rword    (mem[widx]),
      .be       (be),
      .wdata_al (wal),
      .rdata_ext(rext),
      .misalign (misalign)
   );

   // state register and sweep counter; reset always restarts the sweep at word 0
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= (state == ST_INIT) ? cnt + 1'b1 : cnt;
      end

   // leave INIT once the last word has been written
   always_comb state_nx = (state == ST_INIT && cnt == WI'(DEPTH - 1)) ? ST_RUN : state;

   // requests are only taken once the sweep is done
   always_comb req_ready = (state == ST_RUN);

   // single write port shared by the init sweep and byte-enabled stores
   always_ff @(posedge clk)
      if (state == ST_INIT)
         mem[cnt] <= INIT_VAL;
      else if (acc && req_we && !err)
         for (int b = 0; b < NB; b++)
            if (be[b]) mem[widx][8*b +: 8] <= wal[8*b +: 8];

   // response shift register; stage 0 is loaded at the accepting edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pv <= '0;
         pe <= '0;
         pd <= '0;
      end else begin
         pv <= RD_LAT'({pv, acc});
         pe <= RD_LAT'({pe, acc && err});
         pd <= PW'({pd, d0});
      end

   assign rsp_valid = pv[RD_LAT-1];
   assign rsp_err   = pe[RD_LAT-1];
   assign rsp_rdata = pd[RD_LAT-1];
endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised byte-addressable data memory for the MIPS32 pipeline's MEM stage, replacing the word-only data memory. It supports byte/half/word (and dword when DATA_W=64) stores through byte-lane enables, and loads with sign or zero extension. Alignment and range errors are flagged on the response. Reads have a fixed 1- or 2-cycle latency. After every reset a hardware init sweep fills the array with INIT_VAL, replacing simulation-only initialisation.

## Interface
- DATA_W, 32: word width in bits; 32 or 64.
- DEPTH, 64: number of words; power of two, ≥ 2.
- RD_LAT, 1: response latency in cycles after acceptance; 1 or 2.
- INIT_VAL, all-ones: value written to every word by the init sweep.
- ADDR_W, derived: $clog2(DEPTH) + $clog2(DATA_W/8); byte-address width.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request; low during init sweep.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64).
- req_unsigned  in  1  loads only: 1 zero-extends, 0 sign-extends.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse per accepted request, loads and stores.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned, out of range, or used an illegal size.

## Operation
- FSM states are INIT and RUN. Reset forces INIT and sets the sweep counter to 0.
- INIT: each cycle writes INIT_VAL to word[counter] and increments the counter. After writing word DEPTH-1, the FSM moves to RUN. INIT lasts exactly DEPTH cycles. req_ready=0 throughout.
- RUN: req_ready=1. A request is accepted on a posedge when req_valid && req_ready.
- Lane index = req_addr[LB-1:0], where LB = $clog2(DATA_W/8). Word index = req_addr[ADDR_W-1:LB].
- Error conditions:
  - size > LB (illegal size);
  - lane index not a multiple of 2^size (misaligned).
  - Because DEPTH is a power of two, an out-of-range word index cannot occur.
  - An errored store does not modify the array. Errored requests return rsp_err=1 and rsp_rdata=0.
- Store: the low 2^size bytes of req_wdata are placed at lane index. Only those byte lanes are written. All other bytes of the word are preserved.
- Load: the word is shifted right by lane*8. It is then truncated to 2^size bytes and extended to DATA_W, with sign- or zero-extension set by req_unsigned. A full-width load ignores req_unsigned.
- Storage is single-port: one request per cycle, no simultaneous read and write.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. The pipeline valid bits are cleared.
- Latency: rsp_* is valid exactly RD_LAT cycles after the accepting edge. Throughput is one request per cycle with no bubbles.
- No response backpressure: the consumer must sample rsp_* while rsp_valid=1.
- Ordering:
  - responses are returned in request order;
  - a load accepted the cycle after a store to the same word returns the stored data;
  - array writes occur at the accepting edge.
- rst_n asserted mid-operation:
  - all in-flight responses are dropped, with no rsp_valid;
  - array contents are re-initialised by a fresh INIT sweep;
  - a partially completed sweep restarts at word 0.
- Requests presented during INIT are ignored. The requester must hold req_valid until req_ready is high.

## Structure
- Package dmem_pkg holds:
  - size encoding constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3;
  - the FSM state enum {ST_INIT, ST_RUN};
  - a function computing byte-enable masks from size and lane index.
- Sub-module dmem_lane_align is purely combinational. Inputs: size, lane index, unsigned, wdata, raw read word. Outputs: byte-enable mask, aligned write data, extended load data, misalign flag.
- Top level contains: the array (reg per byte lane, or a byte-enabled RAM template), the INIT FSM and counter, and the RD_LAT response pipeline.

## Test plan
- Reset then idle:
  - req_ready rises exactly DEPTH cycles after rst_n deasserts;
  - a word load of address 0x0 then returns 0xFFFFFFFF with rsp_err=0.
- Store byte 0xA5 to addr 0x6 after init:
  - a word load of 0x4 returns 0xFFA5FFFF;
  - a signed byte load of 0x6 returns 0xFFFFFFA5;
  - an unsigned byte load of 0x6 returns 0x000000A5.
- Store half 0x8001 to addr 0x2:
  - a signed half load returns 0xFFFF8001; an unsigned half load returns 0x00008001.
  - Back-to-back loads give rsp_valid on consecutive cycles, with RD_LAT honoured for both RD_LAT=1 and RD_LAT=2 builds.
- Misaligned and illegal requests:
  - a word store to addr 0x5 gives rsp_err=1 and the memory is unchanged (a word load of 0x4 is still 0xFFFFFFFF);
  - a half load at 0x3 gives rsp_err=1 and rdata=0;
  - size=3 with DATA_W=32 gives rsp_err=1.
- Store then immediately load the same word, with a word store of 0x12345678 to 0x8 followed next cycle by a load of 0x8: the load returns 0x12345678.
- Reset mid-traffic: assert rst_n low while loads are in flight. There must be no stale rsp_valid. After the new sweep, previously stored words read back as INIT_VAL.
